hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage processor. Watches decode/execute register usage, the conditional-logic outputs (`branch_taken` in Execute, `pc_src_w` in Writeback) and the data-memory ready line, and issues per-stage stall and flush controls. A small FSM sequences the multi-cycle PC-write wait and the memory freeze. All hazard sequencing in the pipeline lives here; the datapath registers only consume the stall and flush controls.

---
 rtl/hazard_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller bundle: decode/execute register usage and
// conditional-logic inputs in, per-stage stall/flush controls out.
interface hazard_if #(
  parameter int REG_W = 4
);
  logic [REG_W-1:0] ra1_d;
  logic [REG_W-1:0] ra2_d;
  logic [REG_W-1:0] wa_e;
  logic             mem_to_reg_e;
  logic             reg_write_e;
  logic             pc_write_d;
  logic             branch_taken;
  logic             pc_src_w;
  logic             mem_busy;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic [15:0]      stall_cnt;
  logic [15:0]      flush_cnt;

  modport master (
    output ra1_d, ra2_d, wa_e, mem_to_reg_e, reg_write_e,
    output pc_write_d, branch_taken, pc_src_w, mem_busy,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, stall_cnt, flush_cnt
  );

  modport slave (
    input  ra1_d, ra2_d, wa_e, mem_to_reg_e, reg_write_e,
    input  pc_write_d, branch_taken, pc_src_w, mem_busy,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing for the 5-stage core.
// Optional perf counters built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int REG_W      = 4,
  parameter int PCWAIT_CYC = 3
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PCWAIT  = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  state_e     state_q, state_d, eff;
  logic [1:0] cnt_q, cnt_d;
  logic       saved_q, saved_d;
  logic       lu;
  logic       sf, sd, se, sm, fd, fe;

  // Load-use detection against the Execute destination.
  always_comb begin
    lu = hz.mem_to_reg_e & hz.reg_write_e &
         ((hz.ra1_d == hz.wa_e) | (hz.ra2_d == hz.wa_e));
  end

  // Next-state and stall/flush decode; MEMWAIT exit acts as saved state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    saved_d = saved_q;
    sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0;
    fd = 1'b0; fe = 1'b0;
    eff = state_q;
    if (state_q == MEMWAIT)
      eff = saved_q ? PCWAIT : RUN;
    if (hz.mem_busy) begin
      sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1;
      state_d = MEMWAIT;
      saved_d = (eff == PCWAIT);
    end else begin
      state_d = eff;
      unique case (eff)
        RUN: begin
          if (hz.branch_taken) begin
            fd = 1'b1;
            fe = 1'b1;
          end else if (hz.pc_write_d) begin
            sf = 1'b1;
            fd = 1'b1;
            cnt_d   = 2'(PCWAIT_CYC);
            state_d = PCWAIT;
          end else if (lu) begin
            sf = 1'b1;
            sd = 1'b1;
            fe = 1'b1;
          end
        end
        PCWAIT: begin
          sf = 1'b1;
          fd = 1'b1;
          if (hz.branch_taken) begin
            fe = 1'b1;
            state_d = RUN;
          end else if (hz.pc_src_w || cnt_q == 2'd1) begin
            sf = 1'b0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State, wait counter and MEMWAIT return record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      saved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      saved_q <= saved_d;
    end
  end

  assign hz.stall_f = reset & sf;
  assign hz.stall_d = reset & sd;
  assign hz.stall_e = reset & se;
  assign hz.stall_m = reset & sm;
  assign hz.flush_d = reset & fd;
  assign hz.flush_e = reset & fe;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (sf && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if ((fd | fe) && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = 16'd0;
  assign hz.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan sequences
// followed by randomized traffic against a freeze/countdown model.
module tb_hazard_ctrl;

  localparam int PCW = 3;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa;
    logic       m2r;
    logic       rw;
    logic       pcw;
    logic       bt;
    logic       psw;
    logic       mb;
  } in_t;

  typedef struct packed {
    logic        sf;
    logic        sd;
    logic        se;
    logic        sm;
    logic        fd;
    logic        fe;
    logic [15:0] sc;
    logic [15:0] fc;
  } out_t;

  logic clk;
  logic reset;

  hazard_if #(.REG_W(4)) hz();

  hazard_ctrl #(.REG_W(4), .PCWAIT_CYC(PCW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   left_m      = 0;
  int   sc_m        = 0;
  int   fc_m        = 0;

  function automatic in_t vin(
    input logic m2r, input logic rw, input logic pcw,
    input logic bt, input logic psw, input logic mb,
    input logic [3:0] ra1, input logic [3:0] ra2,
    input logic [3:0] wa
  );
    in_t v;
    v.ra1 = ra1; v.ra2 = ra2; v.wa = wa;
    v.m2r = m2r; v.rw = rw; v.pcw = pcw;
    v.bt = bt; v.psw = psw; v.mb = mb;
    return v;
  endfunction

  task automatic apply(input in_t v, input logic rst);
    out_t e;
    logic lu;
    @(posedge clk);
    #1;
    reset           = rst;
    hz.ra1_d        = v.ra1;
    hz.ra2_d        = v.ra2;
    hz.wa_e         = v.wa;
    hz.mem_to_reg_e = v.m2r;
    hz.reg_write_e  = v.rw;
    hz.pc_write_d   = v.pcw;
    hz.branch_taken = v.bt;
    hz.pc_src_w     = v.psw;
    hz.mem_busy     = v.mb;
    e  = '0;
    lu = v.m2r & v.rw & ((v.ra1 == v.wa) | (v.ra2 == v.wa));
    if (!rst) begin
      left_m = 0;
      sc_m   = 0;
      fc_m   = 0;
    end else begin
      if (v.mb) begin
        {e.sf, e.sd, e.se, e.sm} = 4'hF;
      end else if (left_m > 0) begin
        e.sf = 1'b1;
        e.fd = 1'b1;
        if (v.bt) begin
          e.fe   = 1'b1;
          left_m = 0;
        end else if (v.psw || left_m == 1) begin
          e.sf   = 1'b0;
          left_m = 0;
        end else begin
          left_m = left_m - 1;
        end
      end else if (v.bt) begin
        e.fd = 1'b1;
        e.fe = 1'b1;
      end else if (v.pcw) begin
        e.sf   = 1'b1;
        e.fd   = 1'b1;
        left_m = PCW;
      end else if (lu) begin
        e.sf = 1'b1;
        e.sd = 1'b1;
        e.fe = 1'b1;
      end
`ifdef HAZARD_PERF_EN
      e.sc = sc_m[15:0];
      e.fc = fc_m[15:0];
      if (e.sf && sc_m < 65535) sc_m = sc_m + 1;
      if ((e.fd || e.fe) && fc_m < 65535) fc_m = fc_m + 1;
`endif
    end
    expq.push_back(e);
  endtask

  // Monitor: compare the live outputs against the oldest expectation.
  always @(negedge clk) begin
    out_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
           hz.flush_d, hz.flush_e, hz.stall_cnt, hz.flush_cnt};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL ctl t=%0t: got sf%b sd%b se%b sm%b fd%b fe%b sc%0d fc%0d, need sf%b sd%b se%b sm%b fd%b fe%b sc%0d fc%0d",
                 $time, a.sf, a.sd, a.se, a.sm, a.fd, a.fe, a.sc, a.fc,
                 e.sf, e.sd, e.se, e.sm, e.fd, e.fe, e.sc, e.fc);
      end
    end
  end

  in_t idle;
  in_t v;

  initial begin
    reset = 1'b0;
    hz.ra1_d = '0; hz.ra2_d = '0; hz.wa_e = '0;
    hz.mem_to_reg_e = 1'b0; hz.reg_write_e = 1'b0;
    hz.pc_write_d = 1'b0; hz.branch_taken = 1'b0;
    hz.pc_src_w = 1'b0; hz.mem_busy = 1'b0;
    idle = vin(0, 0, 0, 0, 0, 0, 4'd1, 4'd3, 4'd5);

    apply(idle, 1'b0);
    apply(idle, 1'b0);
    apply(idle, 1'b1);

    apply(vin(1, 1, 0, 0, 0, 0, 4'd2, 4'd7, 4'd2), 1'b1);
    apply(idle, 1'b1);

    apply(vin(1, 1, 1, 1, 0, 0, 4'd2, 4'd7, 4'd2), 1'b1);
    apply(idle, 1'b1);

    apply(vin(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd9), 1'b1);
    apply(idle, 1'b1);
    apply(idle, 1'b1);
    apply(vin(0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd9), 1'b1);
    apply(idle, 1'b1);

    apply(vin(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd9), 1'b1);
    repeat (5) apply(idle, 1'b1);

    apply(vin(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd9), 1'b1);
    apply(idle, 1'b1);
    apply(vin(0, 0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd9), 1'b1);
    apply(vin(0, 0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd9), 1'b1);
    repeat (4) apply(idle, 1'b1);

    apply(vin(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd9), 1'b1);
    apply(idle, 1'b1);
    apply(idle, 1'b0);
    repeat (3) apply(idle, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      v.ra1 = 4'($urandom_range(0, 3));
      v.ra2 = 4'($urandom_range(0, 3));
      v.wa  = 4'($urandom_range(0, 3));
      v.m2r = ($urandom_range(0, 1) == 0);
      v.rw  = ($urandom_range(0, 3) != 0);
      v.pcw = ($urandom_range(0, 4) == 0);
      v.bt  = ($urandom_range(0, 6) == 0);
      v.mb  = ($urandom_range(0, 4) == 0);
      v.psw = (left_m > 0) && ($urandom_range(0, 3) == 0);
      apply(v, ($urandom_range(0, 199) != 0));
    end

`ifdef HAZARD_PERF_EN
    apply(idle, 1'b0);
    repeat (65540) apply(vin(0, 0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd9), 1'b1);
    repeat (3) apply(idle, 1'b1);
`endif

    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, need 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
